// File: rtl/cluster_clk_rst_seq.sv
// Cluster clock/reset sequencer: staggered cken ramp, global reset/debug-init hold and release.
// Optional CLU_SEQ_INSYNC_EN adds two-flop input synchronizers (+2 cycles request latency).
module cluster_clk_rst_seq #(
  parameter int NUM_CLUSTERS = 4,
  parameter int CKEN_STAGGER = 4,
  parameter int GRST_HOLD    = 16,
  parameter int DBG_HOLD     = 8
) (
  input  logic                    gclk,
  input  logic                    arst_l,
  input  logic [NUM_CLUSTERS-1:0] cluster_en,
  input  logic                    warm_rst_req,
  input  logic                    dbginit_req,
  output logic [NUM_CLUSTERS-1:0] cluster_cken,
  output logic                    grst_l,
  output logic                    gdbginit_l,
  output logic                    rst_busy,
  output logic                    seq_done
);

  localparam int MAX_SG = (CKEN_STAGGER > GRST_HOLD) ? CKEN_STAGGER : GRST_HOLD;
  localparam int MAX_C  = (MAX_SG > DBG_HOLD) ? MAX_SG : DBG_HOLD;
  localparam int CW     = $clog2(MAX_C) + 1;
  localparam int SW     = $clog2(NUM_CLUSTERS + 1);

  localparam logic [CW-1:0] STAG_LAST = CW'(CKEN_STAGGER - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(GRST_HOLD - 1);
  localparam logic [CW-1:0] DBG_LAST  = CW'(DBG_HOLD - 1);
  localparam logic [SW-1:0] SLOT_LAST = SW'(NUM_CLUSTERS - 1);

  typedef enum logic [1:0] {RAMP, HOLD, RUN, DBG} state_e;

  logic                    warm_s, dbg_s;
  logic [NUM_CLUSTERS-1:0] en_s;

`ifdef CLU_SEQ_INSYNC_EN
  logic [1:0]              warm_sync_q, dbg_sync_q;
  logic [NUM_CLUSTERS-1:0] en_sync1_q, en_sync2_q;

  always_ff @(posedge gclk or negedge arst_l) begin
    if (!arst_l) begin
      warm_sync_q <= '0;
      dbg_sync_q  <= '0;
      en_sync1_q  <= '0;
      en_sync2_q  <= '0;
    end else begin
      warm_sync_q <= {warm_sync_q[0], warm_rst_req};
      dbg_sync_q  <= {dbg_sync_q[0], dbginit_req};
      en_sync1_q  <= cluster_en;
      en_sync2_q  <= en_sync1_q;
    end
  end

  assign warm_s = warm_sync_q[1];
  assign dbg_s  = dbg_sync_q[1];
  assign en_s   = en_sync2_q;
`else
  assign warm_s = warm_rst_req;
  assign dbg_s  = dbginit_req;
  assign en_s   = cluster_en;
`endif

  state_e                  state_q;
  logic [CW-1:0]           cnt_q, cnt_inc;
  logic [SW-1:0]           slot_q;
  logic [NUM_CLUSTERS-1:0] reached_q, reached_d, cken_q;
  logic                    grst_q, dbg_q, busy_q, done_q;

  // Saturating increment shared by the stagger, hold and debug counts.
  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CW'(1);

  always_comb begin
    reached_d = reached_q;
    if (state_q == RAMP && cnt_q == STAG_LAST) begin
      for (int i = 0; i < NUM_CLUSTERS; i++) begin
        if (slot_q == SW'(i)) reached_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge gclk or negedge arst_l) begin
    if (!arst_l) begin
      state_q   <= RAMP;
      cnt_q     <= '0;
      slot_q    <= '0;
      reached_q <= '0;
      cken_q    <= '0;
      grst_q    <= 1'b0;
      dbg_q     <= 1'b0;
      busy_q    <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      reached_q <= reached_d;
      cken_q    <= en_s & reached_d;
      done_q    <= 1'b0;
      case (state_q)
        RAMP: begin
          if (cnt_q == STAG_LAST) begin
            cnt_q <= '0;
            if (slot_q == SLOT_LAST) state_q <= HOLD;
            else                     slot_q  <= slot_q + SW'(1);
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        HOLD: begin
          if (warm_s) begin
            cnt_q <= '0;
          end else if (cnt_q == HOLD_LAST) begin
            grst_q  <= 1'b1;
            dbg_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= RUN;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        RUN: begin
          // Warm has priority; a simultaneous debug-init request is dropped.
          if (warm_s) begin
            grst_q  <= 1'b0;
            dbg_q   <= 1'b0;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
            state_q <= HOLD;
          end else if (dbg_s) begin
            dbg_q   <= 1'b0;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
            state_q <= DBG;
          end
        end
        DBG: begin
          if (warm_s) begin
            grst_q  <= 1'b0;
            cnt_q   <= '0;
            state_q <= HOLD;
          end else if (dbg_s) begin
            cnt_q <= '0;
          end else if (cnt_q == DBG_LAST) begin
            dbg_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= RUN;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        default: state_q <= RAMP;
      endcase
    end
  end

  assign cluster_cken = cken_q;
  assign grst_l       = grst_q;
  assign gdbginit_l   = dbg_q;
  assign rst_busy     = busy_q;
  assign seq_done     = done_q;

endmodule

// File: tb/tb_cluster_clk_rst_seq.sv
// Directed bench for cluster_clk_rst_seq at default parameters; honours CLU_SEQ_INSYNC_EN latency.
module tb_cluster_clk_rst_seq;

`ifdef CLU_SEQ_INSYNC_EN
  localparam int L = 2;
`else
  localparam int L = 0;
`endif

  logic       gclk = 1'b0;
  logic       arst_l = 1'b0;
  logic [3:0] cluster_en = 4'hF;
  logic       warm_rst_req = 1'b0;
  logic       dbginit_req = 1'b0;
  logic [3:0] cluster_cken;
  logic       grst_l, gdbginit_l, rst_busy, seq_done;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;

  cluster_clk_rst_seq dut (
    .gclk(gclk), .arst_l(arst_l), .cluster_en(cluster_en),
    .warm_rst_req(warm_rst_req), .dbginit_req(dbginit_req),
    .cluster_cken(cluster_cken), .grst_l(grst_l), .gdbginit_l(gdbginit_l),
    .rst_busy(rst_busy), .seq_done(seq_done)
  );

  always #5 gclk = ~gclk;

  wire [7:0] obs = {cluster_cken, grst_l, gdbginit_l, rst_busy, seq_done};

  // Expected cken during/after ramp with a constant mask: slot i opens at posedge 4*(i+1).
  function automatic logic [3:0] ramp_cken(input logic [3:0] en, input int n);
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = en[i] && (n >= (i + 1) * 4);
    return r;
  endfunction

  task automatic tick;
    @(posedge gclk);
    #1;
    cyc++;
  endtask

  task automatic do_reset(input logic [3:0] en);
    arst_l = 1'b0;
    warm_rst_req = 1'b0;
    dbginit_req = 1'b0;
    cluster_en = en;
    repeat (2) @(posedge gclk);
    @(negedge gclk);
    arst_l = 1'b1;
    cyc = 0;
  endtask

  task automatic test_reset;
    arst_l = 1'b0;
    cluster_en = 4'hF;
    warm_rst_req = 1'b1;
    dbginit_req = 1'b1;
    repeat (3) @(posedge gclk);
    #1;
    tests_run++;
    if (obs !== 8'b0000_0010) begin
      tests_failed++;
      $display("FAIL reset got=%b exp=%b", obs, 8'b0000_0010);
    end
    warm_rst_req = 1'b0;
    dbginit_req = 1'b0;
  endtask

  task automatic test_power_on(input logic [3:0] en, input string name);
    logic [7:0] exp;
    do_reset(en);
    for (int n = 1; n <= 40; n++) begin
      tick;
      exp = {ramp_cken(en, n), n >= 32, n >= 32, n < 32, n == 32};
      tests_run++;
      if (obs !== exp) begin
        tests_failed++;
        $display("FAIL %s n=%0d got=%b exp=%b", name, n, obs, exp);
      end
    end
  endtask

  task automatic test_warm;
    logic [7:0] exp;
    logic       lo;
    do_reset(4'hF);
    for (int n = 1; n <= 64; n++) begin
      warm_rst_req = (n == 40);
      tick;
      lo = (n < 32) || (n >= 40 + L && n < 56 + L);
      exp = {ramp_cken(4'hF, n), !lo, !lo, lo, (n == 32) || (n == 56 + L)};
      tests_run++;
      if (obs !== exp) begin
        tests_failed++;
        $display("FAIL warm n=%0d got=%b exp=%b", n, obs, exp);
      end
    end
    warm_rst_req = 1'b0;
  endtask

  task automatic test_dbg;
    logic [7:0] exp;
    logic       lo;
    do_reset(4'hF);
    for (int n = 1; n <= 56; n++) begin
      dbginit_req = (n == 40);
      tick;
      lo = (n >= 40 + L && n < 48 + L);
      exp = {ramp_cken(4'hF, n), n >= 32, (n >= 32) && !lo, (n < 32) || lo,
             (n == 32) || (n == 48 + L)};
      tests_run++;
      if (obs !== exp) begin
        tests_failed++;
        $display("FAIL dbg n=%0d got=%b exp=%b", n, obs, exp);
      end
    end
    dbginit_req = 1'b0;
  endtask

  task automatic test_dbg_then_warm;
    logic [7:0] exp;
    logic       glo, dlo;
    do_reset(4'hF);
    for (int n = 1; n <= 66; n++) begin
      dbginit_req = (n == 40);
      warm_rst_req = (n == 44);
      tick;
      glo = (n < 32) || (n >= 44 + L && n < 60 + L);
      dlo = (n < 32) || (n >= 40 + L && n < 60 + L);
      exp = {ramp_cken(4'hF, n), !glo, !dlo, dlo, (n == 32) || (n == 60 + L)};
      tests_run++;
      if (obs !== exp) begin
        tests_failed++;
        $display("FAIL dbg_warm n=%0d got=%b exp=%b", n, obs, exp);
      end
    end
    dbginit_req = 1'b0;
    warm_rst_req = 1'b0;
  endtask

  task automatic test_both_req;
    logic [7:0] exp;
    logic       lo;
    do_reset(4'hF);
    for (int n = 1; n <= 64; n++) begin
      warm_rst_req = (n == 40);
      dbginit_req = (n == 40);
      tick;
      lo = (n < 32) || (n >= 40 + L && n < 56 + L);
      exp = {ramp_cken(4'hF, n), !lo, !lo, lo, (n == 32) || (n == 56 + L)};
      tests_run++;
      if (obs !== exp) begin
        tests_failed++;
        $display("FAIL both_req n=%0d got=%b exp=%b", n, obs, exp);
      end
    end
    warm_rst_req = 1'b0;
    dbginit_req = 1'b0;
  endtask

  // Held warm extends HOLD; debug-init arriving during HOLD is ignored.
  task automatic test_hold_extend;
    logic [7:0] exp;
    logic       lo;
    do_reset(4'hF);
    for (int n = 1; n <= 70; n++) begin
      warm_rst_req = (n >= 40 && n <= 44);
      dbginit_req = (n == 50);
      tick;
      lo = (n < 32) || (n >= 40 + L && n < 60 + L);
      exp = {ramp_cken(4'hF, n), !lo, !lo, lo, (n == 32) || (n == 60 + L)};
      tests_run++;
      if (obs !== exp) begin
        tests_failed++;
        $display("FAIL hold_extend n=%0d got=%b exp=%b", n, obs, exp);
      end
    end
    warm_rst_req = 1'b0;
    dbginit_req = 1'b0;
  endtask

  task automatic test_dbg_restart;
    logic [7:0] exp;
    logic       lo;
    do_reset(4'hF);
    for (int n = 1; n <= 60; n++) begin
      dbginit_req = (n == 40) || (n == 45);
      tick;
      lo = (n >= 40 + L && n < 53 + L);
      exp = {ramp_cken(4'hF, n), n >= 32, (n >= 32) && !lo, (n < 32) || lo,
             (n == 32) || (n == 53 + L)};
      tests_run++;
      if (obs !== exp) begin
        tests_failed++;
        $display("FAIL dbg_restart n=%0d got=%b exp=%b", n, obs, exp);
      end
    end
    dbginit_req = 1'b0;
  endtask

  // Mask changes mid-ramp and in RUN: reached slots follow one cycle later.
  task automatic test_en_track;
    logic [7:0] exp;
    logic [3:0] en_then, ck;
    int         m;
    do_reset(4'hF);
    for (int n = 1; n <= 45; n++) begin
      cluster_en = (n < 10) ? 4'hF : (n < 36) ? 4'h6 : 4'h5;
      tick;
      m = n - L;
      en_then = (m < 10) ? 4'hF : (m < 36) ? 4'h6 : 4'h5;
      for (int i = 0; i < 4; i++) ck[i] = en_then[i] && (n >= (i + 1) * 4);
      exp = {ck, n >= 32, n >= 32, n < 32, n == 32};
      tests_run++;
      if (obs !== exp) begin
        tests_failed++;
        $display("FAIL en_track n=%0d got=%b exp=%b", n, obs, exp);
      end
    end
    cluster_en = 4'hF;
  endtask

  task automatic test_arst_mid;
    logic [7:0] exp;
    do_reset(4'hF);
    repeat (20) tick;
    tests_run++;
    if (obs !== 8'b1111_0010) begin
      tests_failed++;
      $display("FAIL arst_pre n=%0d got=%b exp=%b", cyc, obs, 8'b1111_0010);
    end
    arst_l = 1'b0;
    #1;
    tests_run++;
    if (obs !== 8'b0000_0010) begin
      tests_failed++;
      $display("FAIL arst_async got=%b exp=%b", obs, 8'b0000_0010);
    end
    @(negedge gclk);
    arst_l = 1'b1;
    cyc = 0;
    for (int n = 1; n <= 34; n++) begin
      tick;
      exp = {ramp_cken(4'hF, n), n >= 32, n >= 32, n < 32, n == 32};
      tests_run++;
      if (obs !== exp) begin
        tests_failed++;
        $display("FAIL arst_reramp n=%0d got=%b exp=%b", n, obs, exp);
      end
    end
  endtask

  initial begin
    test_reset;
    test_power_on(4'b1111, "power_on_1111");
    test_power_on(4'b1010, "power_on_1010");
    test_warm;
    test_dbg;
    test_dbg_then_warm;
    test_both_req;
    test_hold_extend;
    test_dbg_restart;
    test_en_track;
    test_arst_mid;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
